// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding and load-use hazard unit for the 5-stage pipeline.
// Tracks in-flight destination records in a shift register and produces
// per-operand forward selects registered to line up with the EX stage.
//
// Optional build macro: FWD_HAZARD_MULDIV_EN adds a multi-cycle multiply
// busy tracker (port issue_is_mul, parameter MUL_LAT).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   issue_valid     ID holds a real instruction
//   issue_regwrite  issuing instruction writes rd
//   issue_is_load   issuing instruction is a load
//   issue_rd        destination register of the issuing instruction
//   issue_src       source addresses, operand i at [i*ADDR_W +: ADDR_W]
//   issue_is_mul    (macro only) issuing instruction is a multiply
//   flush           kill the issuing instruction
//   stall           combinational; hold PC and IF/ID
//   fwd_sel         registered forward selects, operand i at [i*SEL_W +: SEL_W]
module fwd_hazard_unit #(
  parameter int NUM_SRC    = 2,
  parameter int ADDR_W     = 5,
  parameter int FWD_STAGES = 2,
`ifdef FWD_HAZARD_MULDIV_EN
  parameter int MUL_LAT    = 3,
`endif
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  input  logic                      issue_regwrite,
  input  logic                      issue_is_load,
  input  logic [ADDR_W-1:0]         issue_rd,
  input  logic [NUM_SRC*ADDR_W-1:0] issue_src,
`ifdef FWD_HAZARD_MULDIV_EN
  input  logic                      issue_is_mul,
`endif
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel
);

  // The record that would sit at stage FWD_STAGES+1 can never produce a
  // forward, and is_load is only consulted at stage 1, so neither is stored.
  logic              rec_valid [1:FWD_STAGES];
  logic              rec_rw    [1:FWD_STAGES];
  logic [ADDR_W-1:0] rec_rd    [1:FWD_STAGES];
  logic              rec1_is_load;

  logic                     accept;
  logic                     load_use;
  logic                     mul_stall;
  logic [NUM_SRC*SEL_W-1:0] fwd_next;

  function automatic logic rec_match(input logic v, input logic rw,
                                     input logic [ADDR_W-1:0] rd,
                                     input logic [ADDR_W-1:0] src);
    return v && rw && (rd != '0) && (rd == src);
  endfunction

  always_comb begin
    load_use = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (rec_match(rec_valid[1], rec_rw[1], rec_rd[1], issue_src[i*ADDR_W +: ADDR_W]))
        load_use = 1'b1;
    end
    load_use = load_use && rec1_is_load;
  end

  assign stall  = issue_valid && !flush && (load_use || mul_stall);
  assign accept = issue_valid && !stall && !flush;

  // Nearest stage wins: scan from stage 1 outward and keep the first hit.
  always_comb begin
    logic found;
    fwd_next = '0;
    found    = 1'b0;
    if (accept) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        found = 1'b0;
        for (int unsigned k = 1; k <= FWD_STAGES; k++) begin
          if (!found && rec_match(rec_valid[k], rec_rw[k], rec_rd[k],
                                  issue_src[i*ADDR_W +: ADDR_W])) begin
            fwd_next[i*SEL_W +: SEL_W] = SEL_W'(k);
            found = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 1; k <= FWD_STAGES; k++) begin
        rec_valid[k] <= 1'b0;
        rec_rw[k]    <= 1'b0;
        rec_rd[k]    <= '0;
      end
      rec1_is_load <= 1'b0;
      fwd_sel      <= '0;
    end else begin
      rec_valid[1] <= accept;
      rec_rw[1]    <= issue_regwrite;
      rec_rd[1]    <= issue_rd;
      rec1_is_load <= issue_is_load;
      for (int unsigned k = 2; k <= FWD_STAGES; k++) begin
        rec_valid[k] <= rec_valid[k-1];
        rec_rw[k]    <= rec_rw[k-1];
        rec_rd[k]    <= rec_rd[k-1];
      end
      fwd_sel <= fwd_next;
    end
  end

`ifdef FWD_HAZARD_MULDIV_EN
  localparam int CNT_W = $clog2(MUL_LAT);

  logic [CNT_W-1:0]  mul_cnt;
  logic [ADDR_W-1:0] mul_rd;
  logic              mul_hit;

  // While busy, a second mul or any read of the pending result must wait.
  always_comb begin
    mul_hit = issue_is_mul;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if ((mul_rd != '0) && (issue_src[i*ADDR_W +: ADDR_W] == mul_rd))
        mul_hit = 1'b1;
    end
  end

  assign mul_stall = (mul_cnt != '0) && mul_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cnt <= '0;
      mul_rd  <= '0;
    end else if (accept && issue_is_mul) begin
      mul_cnt <= CNT_W'(MUL_LAT - 1);
      mul_rd  <= issue_rd;
    end else if (mul_cnt != '0) begin
      mul_cnt <= mul_cnt - 1'b1;
    end
  end
`else
  assign mul_stall = 1'b0;
`endif

endmodule
